// File: rtl/multicycle_datapath.sv
// multicycle_datapath: datapath of the multicycle RISC-V core.
// Holds PC/OldPC, the instruction register, the Data/A/WriteData/ALUOut
// holding registers, and a 32x32 register file. It also holds the immediate
// extender and the ALU. It steers the unified-memory address and write data.
// Optional feature: define MULTICYCLE_RF_RESET_EN to clear x1..x31 on reset_n
// low. Without it the register file has no reset and can map to memory.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  immsrc,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ResultSrc,
    input  logic        AdrSrc,
    input  logic [2:0]  ALUControl,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic [31:0] ReadData,
    output logic [31:0] Adr,
    output logic [31:0] WriteData,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        Zero
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Architectural and holding registers
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q;
    logic [31:0] a_q;
    logic [31:0] write_data_q;
    logic [31:0] alu_out_q;

    // Register file storage; entry 0 is never written and never read
    logic [31:0] rf_q [0:31];

    // Decode fields and combinational datapath nets
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_result;
    logic [31:0] result;

    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign rd       = instr_q[11:7];
    assign op       = instr_q[6:0];
    assign funct3   = instr_q[14:12];
    assign funct7b5 = instr_q[30];

    // Read ports are combinational; x0 is forced to zero here, so the
    // storage never needs a dedicated zero entry.
    assign rd1 = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

    // Immediate extender: every format sign-extends from Instr[31]
    always_comb begin
        imm_ext = 32'h0;
        case (immsrc)
            2'b00: imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            2'b01: imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            2'b10: imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                              instr_q[30:25], instr_q[11:8], 1'b0};
            2'b11: imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                              instr_q[20], instr_q[30:21], 1'b0};
            default: imm_ext = 32'h0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        src_a = 32'h0;
        case (ALUSrcA)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = old_pc_q;
            2'b10:   src_a = a_q;
            default: src_a = 32'h0;
        endcase
        src_b = 32'h0;
        case (ALUSrcB)
            2'b00:   src_b = write_data_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = 32'd4;
            default: src_b = 32'h0;
        endcase
    end

    // ALU: wrapping add/sub, bitwise and/or, signed set-less-than
    always_comb begin
        alu_result = 32'h0;
        case (ALUControl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'h0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = 32'h0;
        endcase
    end

    assign Zero = (alu_result == 32'h0);

    // Result mux feeding PC, the register file and the memory address
    always_comb begin
        result = 32'h0;
        case (ResultSrc)
            2'b00:   result = alu_out_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = 32'h0;
        endcase
    end

    assign Adr       = AdrSrc ? result : pc_q;
    assign WriteData = write_data_q;

    // Next-state for the enabled registers; OldPC takes the pre-edge PC
    always_comb begin
        pc_d     = PCWrite ? result : pc_q;
        old_pc_d = IRWrite ? pc_q : old_pc_q;
        instr_d  = IRWrite ? ReadData : instr_q;
    end

    // State registers; the holding registers reload every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            old_pc_q     <= 32'h0;
            instr_q      <= 32'h0;
            data_q       <= 32'h0;
            a_q          <= 32'h0;
            write_data_q <= 32'h0;
            alu_out_q    <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            old_pc_q     <= old_pc_d;
            instr_q      <= instr_d;
            data_q       <= ReadData;
            a_q          <= rd1;
            write_data_q <= rd2;
            alu_out_q    <= alu_result;
        end
    end

`ifdef MULTICYCLE_RF_RESET_EN
    // Register file write port with reset clearing x1..x31
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (RegWrite && (rd != 5'd0)) begin
            rf_q[rd] <= result;
        end
    end
`else
    // Register file write port without reset; writes to x0 are dropped.
    // During reset Instr is zero, so rd is x0 and nothing is written.
    always_ff @(posedge clk) begin
        if (RegWrite && (rd != 5'd0)) begin
            rf_q[rd] <= result;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed instruction sequences for the multicycle
// datapath. The stimulus process drives controller signals cycle by cycle and
// queues expected outputs. A negedge monitor drains the queue and compares.
module tb_multicycle_datapath;

    localparam logic [1:0] SA_PC = 2'b00, SA_OLD = 2'b01, SA_A = 2'b10, SA_ZERO = 2'b11;
    localparam logic [1:0] SB_WD = 2'b00, SB_IMM = 2'b01, SB_4 = 2'b10, SB_ZERO = 2'b11;
    localparam logic [1:0] RS_ALUOUT = 2'b00, RS_DATA = 2'b01, RS_ALURES = 2'b10, RS_ZERO = 2'b11;
    localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

    localparam int S_ADR = 0, S_WD = 1, S_ZERO = 2, S_OP = 3, S_F3 = 4, S_F7 = 5;

    logic        clk;
    logic        reset_n;
    logic [1:0]  immsrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc;
    logic [2:0]  ALUControl;
    logic        IRWrite, PCWrite, RegWrite;
    logic [31:0] ReadData;
    logic [31:0] Adr, WriteData;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;

    multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .immsrc     (immsrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ReadData   (ReadData),
        .Adr        (Adr),
        .WriteData  (WriteData),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    chk_t        cur;
    logic [31:0] got;

    // Monitor: drain every expectation queued for this cycle at the negedge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            case (cur.sel)
                S_ADR:   got = Adr;
                S_WD:    got = WriteData;
                S_ZERO:  got = {31'h0, Zero};
                S_OP:    got = {25'h0, op};
                S_F3:    got = {29'h0, funct3};
                default: got = {31'h0, funct7b5};
            endcase
            n_checks++;
            if (got !== cur.exp) begin
                n_fail++;
                $display("FAIL %s actual=%h required=%h", cur.name, got, cur.exp);
            end else begin
                $display("check %s value=%h ok", cur.name, got);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic [1:0] imm, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] rs, input logic adr, input logic [2:0] aluc,
                       input logic irw, input logic pcw, input logic rw);
        immsrc     = imm;
        ALUSrcA    = sa;
        ALUSrcB    = sb;
        ResultSrc  = rs;
        AdrSrc     = adr;
        ALUControl = aluc;
        IRWrite    = irw;
        PCWrite    = pcw;
        RegWrite   = rw;
    endtask

    // Fetch: PC+4 into PC, ReadData into Instr, PC into OldPC
    task automatic c_fetch(input logic [31:0] instr, input logic [31:0] exp_pc);
        ReadData = instr;
        ctl(IMM_I, SA_PC, SB_4, RS_ALURES, 1'b0, ADD, 1'b1, 1'b1, 1'b0);
        expect_out("fetch_adr", S_ADR, exp_pc);
    endtask

    // Decode: ALUOut <= OldPC + imm, A/WriteData loaded from the register file
    task automatic c_decode(input logic [1:0] imm);
        ctl(imm, SA_OLD, SB_IMM, RS_ALUOUT, 1'b0, ADD, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic c_exec(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                          input logic [2:0] aluc);
        ctl(imm, sa, sb, RS_ALURES, 1'b1, aluc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic c_wb(input logic [1:0] rs);
        ctl(IMM_I, SA_PC, SB_4, rs, 1'b1, ADD, 1'b0, 1'b0, 1'b1);
    endtask

    // One observation cycle: Adr shows ALUResult, no enables asserted
    task automatic look(input string name, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] imm, input logic [2:0] aluc, input logic [31:0] exp);
        ctl(imm, sa, sb, RS_ALURES, 1'b1, aluc, 1'b0, 1'b0, 1'b0);
        expect_out(name, S_ADR, exp);
        tick();
    endtask

    initial begin
        reset_n  = 1'b1;
        ReadData = 32'h0;
        ctl(IMM_I, SA_PC, SB_WD, RS_ALUOUT, 1'b0, ADD, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        tick();

        // Reset state
        expect_out("rst_pc", S_ADR, 32'h0);
        expect_out("rst_wd", S_WD, 32'h0);
        expect_out("rst_op", S_OP, 32'h0);
        expect_out("rst_f3", S_F3, 32'h0);
        expect_out("rst_f7", S_F7, 32'h0);
        expect_out("rst_zero", S_ZERO, 32'h1);
        tick();
        ctl(IMM_I, SA_PC, SB_WD, RS_ALUOUT, 1'b1, ADD, 1'b0, 1'b0, 1'b0);
        expect_out("rst_aluout", S_ADR, 32'h0);
        tick();
        reset_n = 1'b1;

        // addi x1,x0,5 at PC 0
        c_fetch(32'h0050_0093, 32'h0); tick();
        n_checks++;
        if (op !== 7'b0010011) begin
            n_fail++;
            $display("FAIL direct_fetch_op actual=%h required=%h", op, 7'b0010011);
        end else begin
            $display("check direct_fetch_op value=%h ok", op);
        end
        n_checks++;
        if (funct3 !== 3'b000) begin
            n_fail++;
            $display("FAIL direct_fetch_f3 actual=%h required=%h", funct3, 3'b000);
        end else begin
            $display("check direct_fetch_f3 value=%h ok", funct3);
        end
        expect_out("addi_op", S_OP, 32'h13);
        expect_out("addi_f3", S_F3, 32'h0);
        expect_out("addi_f7", S_F7, 32'h0);
        look("oldpc_after_fetch", SA_OLD, SB_ZERO, IMM_I, ADD, 32'h0);
        c_decode(IMM_I); expect_out("pc_after_fetch", S_ADR, 32'h4); tick();
        c_exec(SA_A, SB_IMM, IMM_I, ADD); expect_out("addi_exec", S_ADR, 32'h5); tick();
        c_wb(RS_ALUOUT); expect_out("addi_wb", S_ADR, 32'h5); tick();

        // add x3,x1,x1 at PC 4
        c_fetch(32'h0010_81B3, 32'h4); tick();
        c_decode(IMM_I); expect_out("add_op", S_OP, 32'h33); expect_out("add_pc", S_ADR, 32'h8); tick();
        expect_out("add_wd_x1", S_WD, 32'h5);
        look("add_a_x1", SA_A, SB_ZERO, IMM_I, ADD, 32'h5);
        c_exec(SA_A, SB_WD, IMM_I, ADD); expect_out("add_exec", S_ADR, 32'hA); tick();
        c_wb(RS_ALUOUT); expect_out("add_wb", S_ADR, 32'hA); tick();

        // sw x1,8(x0) at PC 8
        c_fetch(32'h0010_2423, 32'h8); tick();
        c_decode(IMM_S); expect_out("sw_op", S_OP, 32'h23); expect_out("sw_f3", S_F3, 32'h2); tick();
        c_exec(SA_A, SB_IMM, IMM_S, ADD); expect_out("sw_addr_calc", S_ADR, 32'h8); tick();
        ctl(IMM_S, SA_PC, SB_4, RS_ALUOUT, 1'b1, ADD, 1'b0, 1'b0, 1'b0);
        expect_out("sw_mem_adr", S_ADR, 32'h8); expect_out("sw_mem_wd", S_WD, 32'h5); tick();

        // beq x1,x1,+16 at PC 0x0C (taken)
        c_fetch(32'h0010_8863, 32'hC); tick();
        c_decode(IMM_B); expect_out("beq_op", S_OP, 32'h63); expect_out("beq_pc", S_ADR, 32'h10); tick();
        ctl(IMM_B, SA_A, SB_WD, RS_ALUOUT, 1'b1, SUB, 1'b0, 1'b1, 1'b0);
        expect_out("beq_t_zero", S_ZERO, 32'h1); expect_out("beq_t_target", S_ADR, 32'h1C); tick();

        // lw x2,8(x0) at PC 0x1C with memory returning 6
        c_fetch(32'h0080_2103, 32'h1C); tick();
        c_decode(IMM_I); expect_out("lw_op", S_OP, 32'h03); expect_out("lw_f3", S_F3, 32'h2); tick();
        c_exec(SA_A, SB_IMM, IMM_I, ADD); expect_out("lw_addr_calc", S_ADR, 32'h8); tick();
        ReadData = 32'h6;
        ctl(IMM_I, SA_PC, SB_4, RS_ALUOUT, 1'b1, ADD, 1'b0, 1'b0, 1'b0);
        expect_out("lw_mem_adr", S_ADR, 32'h8); tick();
        ReadData = 32'hDEAD_BEEF;
        c_wb(RS_DATA); expect_out("lw_data_reg", S_ADR, 32'h6); tick();

        // beq x1,x2,+16 at PC 0x20 (not taken: 5 vs 6)
        c_fetch(32'h0020_8863, 32'h20); tick();
        c_decode(IMM_B); expect_out("beq_nt_pc", S_ADR, 32'h24); tick();
        ctl(IMM_B, SA_A, SB_WD, RS_ALUOUT, 1'b1, SUB, 1'b0, 1'b0, 1'b0);
        expect_out("beq_nt_wd_x2", S_WD, 32'h6);
        expect_out("beq_nt_zero", S_ZERO, 32'h0); expect_out("beq_nt_target", S_ADR, 32'h30); tick();

        // jal x1,+0x20 at PC 0x24
        c_fetch(32'h0200_00EF, 32'h24); tick();
        c_decode(IMM_J); expect_out("jal_op", S_OP, 32'h6F); tick();
        ctl(IMM_J, SA_OLD, SB_4, RS_ALUOUT, 1'b1, ADD, 1'b0, 1'b1, 1'b0);
        expect_out("jal_target", S_ADR, 32'h44); tick();
        c_wb(RS_ALUOUT); expect_out("jal_link", S_ADR, 32'h28); tick();

        // add x0,x1,x1 at PC 0x44: write to x0 must be dropped
        c_fetch(32'h0010_8033, 32'h44); tick();
        c_decode(IMM_I); tick();
        c_exec(SA_A, SB_WD, IMM_I, ADD); expect_out("addx0_exec", S_ADR, 32'h50); tick();
        c_wb(RS_ALUOUT); tick();

        // add x5,x0,x1 at PC 0x48: read x0 and the jal link in x1
        c_fetch(32'h0010_02B3, 32'h48); tick();
        c_decode(IMM_I); tick();
        expect_out("x1_link_wd", S_WD, 32'h28);
        look("x0_reads_zero", SA_A, SB_ZERO, IMM_I, ADD, 32'h0);
        look("alu_and", SA_PC, SB_WD, IMM_I, AND_, 32'h08);
        look("alu_or", SA_PC, SB_WD, IMM_I, OR_, 32'h6C);
        look("alu_slt_pos", SA_A, SB_WD, IMM_I, SLT, 32'h1);
        look("alu_undef", SA_PC, SB_4, IMM_I, 3'b111, 32'h0);
        ctl(IMM_I, SA_PC, SB_4, RS_ZERO, 1'b1, ADD, 1'b0, 1'b0, 1'b0);
        expect_out("result_zero", S_ADR, 32'h0); tick();

        // addi x4,x0,-3 at PC 0x4C: immediate formats and signed compare
        c_fetch(32'hFFD0_0213, 32'h4C); tick();
        c_decode(IMM_I); tick();
        look("imm_i", SA_ZERO, SB_IMM, IMM_I, ADD, 32'hFFFF_FFFD);
        look("imm_s", SA_ZERO, SB_IMM, IMM_S, ADD, 32'hFFFF_FFE4);
        look("imm_b", SA_ZERO, SB_IMM, IMM_B, ADD, 32'hFFFF_F7E4);
        look("imm_j", SA_ZERO, SB_IMM, IMM_J, ADD, 32'hFFF0_0FFC);
        look("slt_signed", SA_A, SB_IMM, IMM_I, SLT, 32'h0);
        look("sub_wrap", SA_A, SB_IMM, IMM_I, SUB, 32'h3);
        look("add_wrap", SA_PC, SB_IMM, IMM_I, ADD, 32'h4D);

        // addi x1,x1,1 at PC 0x50, reset asserted before writeback
        c_fetch(32'h0010_8093, 32'h50); tick();
        c_decode(IMM_I); tick();
        c_exec(SA_A, SB_IMM, IMM_I, ADD); expect_out("pre_rst_exec", S_ADR, 32'h29); tick();
        c_wb(RS_ALUOUT);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (WriteData !== 32'h0) begin
            n_fail++;
            $display("FAIL direct_midrst_wd actual=%h required=%h", WriteData, 32'h0);
        end else begin
            $display("check direct_midrst_wd value=%h ok", WriteData);
        end
        expect_out("midrst_aluout", S_ADR, 32'h0); tick();
        ctl(IMM_I, SA_PC, SB_4, RS_ALUOUT, 1'b0, ADD, 1'b0, 1'b0, 1'b0);
        expect_out("midrst_pc", S_ADR, 32'h0);
        expect_out("midrst_op", S_OP, 32'h0);
        expect_out("midrst_wd", S_WD, 32'h0); tick();
        reset_n = 1'b1;

        // add x0,x1,x1 at RESET_PC: read x1 back
        c_fetch(32'h0010_8033, 32'h0); tick();
        c_decode(IMM_I); expect_out("post_rst_pc", S_ADR, 32'h4); tick();
`ifdef MULTICYCLE_RF_RESET_EN
        look("x1_after_reset", SA_A, SB_ZERO, IMM_I, ADD, 32'h0);
`else
        look("x1_after_reset", SA_A, SB_ZERO, IMM_I, ADD, 32'h28);
`endif
        tick();

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end else begin
            $display("check scoreboard_drain value=0 ok");
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count actual=%0d required>=12", n_checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
